// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the SRAM front-end controller.
// Optional write-verify build: define SRAM_CTRL_VERIFY_EN.
package sram_ctrl_pkg;

   localparam int ADDR_W_DEF = 11;
   localparam int DATA_W_DEF = 8;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      PULSE,
      HOLD,
      VFY_SETUP,
      VFY_PULSE,
      VFY_HOLD
   } state_t;

   function automatic int timer_w(input int s, input int p, input int h);
      int m;
      m = s;
      if (p > m) m = p;
      if (h > m) m = h;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/sram_pulse_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
// Shared by the setup, pulse and hold phases.
module sram_pulse_timer #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] val,
   output logic         done
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (load)
         cnt <= val;
      else if (cnt != '0)
         cnt <= cnt - W'(1);
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/sram_ctrl.sv
// Valid/ready front end producing timed strobes for the 2K x 8 async SRAM.
// Define SRAM_CTRL_VERIFY_EN to add a read-back check after every write.
module sram_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int SETUP_CYC = 1,
   parameter int PULSE_CYC = 2,
   parameter int HOLD_CYC  = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              reqValid,
   output logic              reqReady,
   input  logic              reqWrite,
   input  logic [ADDR_W-1:0] reqAddr,
   input  logic [DATA_W-1:0] reqWData,
   output logic              rspValid,
   output logic [DATA_W-1:0] rspData,
   output logic              wrDone,
   output logic              verifyErr,
   output logic [ADDR_W-1:0] sramAddr,
   output logic [DATA_W-1:0] sramDataIn,
   input  logic [DATA_W-1:0] sramDataOut,
   output logic              sramChipSelect,
   output logic              sramEnable,
   output logic              sramReadnWrite
);

   localparam int TW = timer_w(SETUP_CYC, PULSE_CYC, HOLD_CYC);

   state_t        state, nxt, after_hold;
   logic          op_wr, rdy, accept;
   logic          tload, tdone;
   logic [TW-1:0] tval;
   logic          cs_d, en_d, rnw_d;
   logic          cap_d, done_d, verr_d;

   assign reqReady = rdy;
   assign accept   = reqValid && rdy;

`ifdef SRAM_CTRL_VERIFY_EN
   assign after_hold = op_wr ? VFY_SETUP : IDLE;
`else
   assign after_hold = IDLE;
`endif

   sram_pulse_timer #(.W(TW)) u_timer (
      .clk  (clk),
      .rst_n(reset),
      .load (tload),
      .val  (tval),
      .done (tdone)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         rdy            <= 1'b0;
         op_wr          <= 1'b0;
         sramAddr       <= '0;
         sramDataIn     <= '0;
         sramChipSelect <= 1'b1;
         sramEnable     <= 1'b1;
         sramReadnWrite <= 1'b1;
         rspValid       <= 1'b0;
         rspData        <= '0;
         wrDone         <= 1'b0;
         verifyErr      <= 1'b0;
      end else begin
         state          <= nxt;
         rdy            <= (nxt == IDLE);
         sramChipSelect <= cs_d;
         sramEnable     <= en_d;
         sramReadnWrite <= rnw_d;
         rspValid       <= cap_d;
         wrDone         <= done_d;
         verifyErr      <= verr_d;
         if (state == IDLE && accept) begin
            op_wr      <= reqWrite;
            sramAddr   <= reqAddr;
            sramDataIn <= reqWData;
         end
         if (cap_d)
            rspData <= sramDataOut;
      end
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:      if (accept) nxt = SETUP;
         SETUP:     if (tdone)  nxt = PULSE;
         PULSE:     if (tdone)  nxt = HOLD;
         HOLD:      if (tdone)  nxt = after_hold;
         VFY_SETUP: if (tdone)  nxt = VFY_PULSE;
         VFY_PULSE: if (tdone)  nxt = VFY_HOLD;
         VFY_HOLD:  if (tdone)  nxt = IDLE;
         default:               nxt = IDLE;
      endcase
   end

   // Strobe values are computed for the next state so they leave flops.
   always_comb begin
      tload = (nxt != state);
      case (nxt)
         SETUP, VFY_SETUP: tval = TW'(SETUP_CYC - 1);
         PULSE, VFY_PULSE: tval = TW'(PULSE_CYC - 1);
         HOLD, VFY_HOLD:   tval = TW'(HOLD_CYC - 1);
         default:          tval = '0;
      endcase
      cs_d   = (nxt == IDLE);
      en_d   = !((nxt == PULSE && !op_wr) || nxt == VFY_PULSE);
      rnw_d  = !(nxt == PULSE && op_wr);
      cap_d  = (state == PULSE) && (nxt == HOLD) && !op_wr;
`ifdef SRAM_CTRL_VERIFY_EN
      done_d = (state == VFY_PULSE) && (nxt == VFY_HOLD);
      verr_d = done_d && (sramDataOut != sramDataIn);
`else
      done_d = (state == PULSE) && (nxt == HOLD) && op_wr;
      verr_d = 1'b0;
`endif
   end

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: SRAM behavioural model, directed table,
// random traffic against a reference memory, corner sequences.
module tb_sram_ctrl;

   localparam int S = 1, P = 2, H = 1;
   localparam int KD_R = S + P + 1;
   localparam int KR_R = S + P + H + 1;
`ifdef SRAM_CTRL_VERIFY_EN
   localparam int KD_W = (S + P + H) + (S + P + 1);
   localparam int KR_W = 2 * (S + P + H) + 1;
   localparam int EN_WR = 3 * P;
`else
   localparam int KD_W = KD_R;
   localparam int KR_W = KR_R;
   localparam int EN_WR = 0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        reqValid = 1'b0, reqWrite = 1'b0;
   logic [10:0] reqAddr = '0;
   logic [7:0]  reqWData = '0;
   logic        reqReady, rspValid, wrDone, verifyErr;
   logic        sramChipSelect, sramEnable, sramReadnWrite;
   logic [7:0]  rspData, sramDataIn, sramDataOut;
   logic [10:0] sramAddr;
   logic [7:0]  dout = '0;
   logic        force0 = 1'b0;

   logic        v1 = 1'b0, w1 = 1'b0;
   logic [10:0] a1 = '0, sa1;
   logic [7:0]  d1 = '0, rd1, sdi1;
   logic        rdy1, rsp1, wd1, ve1, cs1, en1, rnw1;

   int compared = 0, mismatched = 0;
   int cyc = 0, rnw_low = 0, en_low = 0, both_low = 0, addr_bad = 0;
   logic [10:0] cur_a = '0;
   logic [7:0]  mem [0:2047];
   logic [7:0]  ref_mem [0:2047];
   logic [7:0]  last_rd = '0;

   typedef struct {
      bit          wr;
      logic [10:0] a;
      logic [7:0]  d;
      logic [7:0]  exp;
   } vec_t;
   vec_t tbl [8];

   sram_ctrl dut (
      .clk(clk), .reset(reset),
      .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
      .reqAddr(reqAddr), .reqWData(reqWData),
      .rspValid(rspValid), .rspData(rspData), .wrDone(wrDone),
      .verifyErr(verifyErr), .sramAddr(sramAddr), .sramDataIn(sramDataIn),
      .sramDataOut(sramDataOut), .sramChipSelect(sramChipSelect),
      .sramEnable(sramEnable), .sramReadnWrite(sramReadnWrite)
   );

   sram_ctrl #(.SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(2)) u1 (
      .clk(clk), .reset(reset),
      .reqValid(v1), .reqReady(rdy1), .reqWrite(w1),
      .reqAddr(a1), .reqWData(d1),
      .rspValid(rsp1), .rspData(rd1), .wrDone(wd1),
      .verifyErr(ve1), .sramAddr(sa1), .sramDataIn(sdi1),
      .sramDataOut(8'h77), .sramChipSelect(cs1),
      .sramEnable(en1), .sramReadnWrite(rnw1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   assign sramDataOut = force0 ? 8'h00 : dout;

   always @(negedge sramEnable)
      if (reset && !sramChipSelect) dout = mem[sramAddr];
   always @(posedge sramReadnWrite)
      if (reset && !sramChipSelect) mem[sramAddr] = sramDataIn;

   always @(negedge clk) begin
      if (!sramReadnWrite) rnw_low++;
      if (!sramEnable) en_low++;
      if (!sramEnable && !sramReadnWrite) both_low++;
      if (reset && !sramChipSelect && sramAddr !== cur_a) addr_bad++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic op(input bit wr, input logic [10:0] a, input logic [7:0] d,
                     output int kd, output int kr, output logic [7:0] rd,
                     output logic ve);
      int t;
      t = 0;
      @(negedge clk);
      while (!reqReady && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!reqReady) begin
         compared++;
         mismatched++;
         $display("FAIL ready_timeout: got 0 expected 1");
      end
      cur_a = a;
      reqValid = 1'b1; reqWrite = wr; reqAddr = a; reqWData = d;
      @(posedge clk);
      #1;
      reqValid = 1'b0;
      reqWrite = 1'($urandom);
      reqAddr  = 11'($urandom);
      reqWData = 8'($urandom);
      kd = 0; kr = 0; rd = 'x; ve = 1'b0;
      for (int k = 1; k <= 40 && kr == 0; k++) begin
         @(negedge clk);
         if ((rspValid || wrDone) && kd == 0) begin
            kd = k; rd = rspData; ve = verifyErr;
         end
         if (reqReady) kr = k;
      end
      if (wr) ref_mem[a] = d;
   endtask

   task automatic run(input string nm, input bit wr, input logic [10:0] a,
                      input logic [7:0] d, input logic [7:0] exp, input logic ve_exp);
      int kd, kr, r0;
      logic [7:0] rd;
      logic ve;
      r0 = rnw_low;
      op(wr, a, d, kd, kr, rd, ve);
      chk({nm, "_done_lat"}, kd, wr ? KD_W : KD_R);
      chk({nm, "_ready_lat"}, kr, wr ? KR_W : KR_R);
      chk({nm, "_data"}, rd, wr ? last_rd : exp);
      chk({nm, "_verr"}, ve, ve_exp);
      if (wr) chk({nm, "_rnw_low"}, rnw_low - r0, P);
      else last_rd = exp;
   endtask

   initial begin
      int n, kd, kr, e0;
      int acc [3];
      logic [10:0] ra;
      logic [7:0] rdd;
      bit rw;

      for (int i = 0; i < 2048; i++) begin
         mem[i] = '0;
         ref_mem[i] = '0;
      end
      tbl[0] = '{1'b1, 11'h123, 8'hA5, 8'h00};
      tbl[1] = '{1'b0, 11'h123, 8'h00, 8'hA5};
      tbl[2] = '{1'b1, 11'h7FF, 8'h3C, 8'h00};
      tbl[3] = '{1'b0, 11'h7FF, 8'h00, 8'h3C};
      tbl[4] = '{1'b0, 11'h000, 8'h00, 8'h00};
      tbl[5] = '{1'b1, 11'h000, 8'hFF, 8'h00};
      tbl[6] = '{1'b0, 11'h000, 8'h00, 8'hFF};
      tbl[7] = '{1'b0, 11'h123, 8'h00, 8'hA5};

      repeat (2) @(negedge clk);
      chk("rst_ready", reqReady, 0);
      chk("rst_strobes", {sramChipSelect, sramEnable, sramReadnWrite}, 3'b111);
      chk("rst_addr_data", {sramAddr, sramDataIn}, 0);
      chk("rst_rsp", {rspValid, wrDone, verifyErr, rspData}, 0);
      reset = 1'b1;
      #1;
      chk("rel_ready_0", reqReady, 0);
      @(negedge clk);
      chk("rel_ready_1", reqReady, 1);

      for (int i = 0; i < 8; i++)
         run($sformatf("tbl%0d", i), tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].exp, 1'b0);

      // three writes with reqValid held high
      e0 = en_low;
      n = 0;
      @(negedge clk);
      reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 11'h010; reqWData = 8'h60;
      for (int i = 0; i < 60 && n < 3; i++) begin
         if (reqReady) begin
            acc[n] = cyc;
            ref_mem[reqAddr] = reqWData;
            cur_a = reqAddr;
            n++;
            @(posedge clk);
            #1;
            reqAddr = 11'h010 + 11'(n);
            reqWData = 8'h60 + 8'(n);
         end
         @(negedge clk);
      end
      reqValid = 1'b0;
      chk("b2b_count", n, 3);
      chk("b2b_gap1", acc[1] - acc[0], KR_W);
      chk("b2b_gap2", acc[2] - acc[1], KR_W);
      for (int i = 0; i < 4; i++) @(negedge clk);
      chk("b2b_en_low", en_low - e0, EN_WR);
      for (int i = 0; i < 3; i++)
         run($sformatf("b2b_rd%0d", i), 1'b0, 11'h010 + 11'(i), 8'h00,
             8'h60 + 8'(i), 1'b0);

      for (int i = 0; i < 40; i++) begin
         rw = 1'($urandom);
         ra = 11'h200 + 11'($urandom_range(0, 7));
         run("rnd", rw, ra, 8'($urandom), ref_mem[ra], 1'b0);
      end

      // slow-timing instance
      n = 0;
      @(negedge clk);
      while (!rdy1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      v1 = 1'b1; w1 = 1'b0; a1 = 11'h321;
      @(posedge clk);
      #1;
      v1 = 1'b0;
      kd = 0; kr = 0; rdd = '0;
      for (int k = 1; k <= 20 && kr == 0; k++) begin
         @(negedge clk);
         if (rsp1 && kd == 0) begin kd = k; rdd = rd1; end
         if (rdy1) kr = k;
      end
      chk("slow_rsp_lat", kd, 6);
      chk("slow_ready_lat", kr, 8);
      chk("slow_data", rdd, 8'h77);

`ifdef SRAM_CTRL_VERIFY_EN
      force0 = 1'b1;
      run("vfy_force", 1'b1, 11'h0AA, 8'h5A, 8'h00, 1'b1);
      force0 = 1'b0;
`endif

      // reset during a write pulse
      run("pre_rst", 1'b1, 11'h055, 8'h11, 8'h00, 1'b0);
      @(negedge clk);
      cur_a = 11'h055;
      reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 11'h055; reqWData = 8'h99;
      @(posedge clk);
      #1;
      reqValid = 1'b0;
      n = 0;
      @(negedge clk);
      while (sramReadnWrite && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("midrst_in_pulse", sramReadnWrite, 0);
      reset = 1'b0;
      #1;
      chk("midrst_strobes", {sramChipSelect, sramEnable, sramReadnWrite}, 3'b111);
      chk("midrst_ready", reqReady, 0);
      n = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (wrDone || rspValid) n++;
      end
      chk("midrst_no_done", n, 0);
      reset = 1'b1;
      #1;
      chk("midrst_rel_ready_0", reqReady, 0);
      @(negedge clk);
      chk("midrst_rel_ready_1", reqReady, 1);
      chk("midrst_no_done2", wrDone, 0);
      last_rd = '0;
      run("midrst_rd", 1'b0, 11'h055, 8'h00, 8'h11, 1'b0);

      chk("never_both_low", both_low, 0);
      chk("addr_stable", addr_bad, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
